// File: rtl/mdio_pkg.sv
// Shared constants and types for the Clause-22 MDIO responder.
package mdio_pkg;

   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] ST    = 2'b01;

   localparam int PHYAD_W   = 5;
   localparam int REGAD_W   = 5;
   localparam int TA_W      = 2;
   localparam int DATA_W    = 16;
   localparam int SKIP_BITS = REGAD_W + TA_W + DATA_W;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ST2,
      S_OP,
      S_PHYAD,
      S_REGAD,
      S_TA,
      S_WDATA,
      S_RDATA,
      S_SKIP
   } state_e;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings the asynchronous MDC/MDIO pads into the system clock domain and
// flags each MDC rising edge with a one-clk pulse.
module mdio_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic mdc_i,
   input  logic mdi_i,
   output logic mdi_o,
   output logic rise_o
);

   logic [1:0] mdcSync_q;
   logic [1:0] mdiSync_q;
   logic       mdcPrev_q;

   // Two-flop synchronisers, plus one extra stage on MDC for edge detection.
   // MDIO resets to '1' because the idle bus is pulled up.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mdcSync_q <= 2'b00;
         mdiSync_q <= 2'b11;
         mdcPrev_q <= 1'b0;
      end else begin
         mdcSync_q <= {mdcSync_q[0], mdc_i};
         mdiSync_q <= {mdiSync_q[0], mdi_i};
         mdcPrev_q <= mdcSync_q[1];
      end
   end

   assign rise_o = mdcSync_q[1] & ~mdcPrev_q;
   assign mdi_o  = mdiSync_q[1];

endmodule

// File: rtl/mdio_slave_if.sv
// Clause-22 MDIO responder: decodes write/read frames addressed to PHYA and
// bridges them onto a simple 32x16 register-file port.
module mdio_slave_if
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHYA     = 5'b00001,
   parameter int         PRE_MIN  = 32,
   parameter bit         BCAST_EN = 1'b0,
   parameter int         TIMEOUT  = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mdc_i,
   input  logic        mdi_i,
   output logic        mdo_o,
   output logic        mdt_o,
   output logic [4:0]  reg_addr_o,
   output logic        reg_wr_o,
   output logic [15:0] reg_wdata_o,
   output logic        reg_rd_o,
   input  logic [15:0] reg_rdata_i,
   output logic        busy_o
);

   localparam int PRE_W = $clog2(PRE_MIN + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic              mdiSync;
   logic              mdcRise;

   state_e            state_q;
   logic [PRE_W-1:0]  preCnt_q;
   logic [TMO_W-1:0]  tmoCnt_q;
   logic [TMO_W-1:0]  tmoCnt_d;
   logic              tmoHit;
   logic [4:0]        bitCnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              opFirst_q;
   logic              isRead_q;
   logic              mdo_q;
   logic              mdt_q;
   logic              busy_q;
   logic              reg_wr_q;
   logic              reg_rd_q;
   logic [4:0]        reg_addr_q;
   logic [DATA_W-1:0] reg_wdata_q;

   logic [1:0]        opCode;
   logic [4:0]        fieldVal;
   logic              addrMatch;

   mdio_edge_sync uSync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .mdc_i  (mdc_i),
      .mdi_i  (mdi_i),
      .mdi_o  (mdiSync),
      .rise_o (mdcRise)
   );

   // Field values completed by the bit arriving on the current rise.
   always_comb begin
      opCode    = {opFirst_q, mdiSync};
      fieldVal  = {shift_q[3:0], mdiSync};
      addrMatch = (fieldVal == PHYA) ||
                  (BCAST_EN && (fieldVal == 5'd0) && !isRead_q);
   end

   // Stalled-MDC watchdog: cleared by every rise, frozen while idle.
   always_comb begin
      tmoHit   = 1'b0;
      tmoCnt_d = tmoCnt_q;
      if (mdcRise) begin
         tmoCnt_d = '0;
      end else if (state_q != S_IDLE) begin
         if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
            tmoHit   = 1'b1;
            tmoCnt_d = '0;
         end else begin
            tmoCnt_d = tmoCnt_q + 1'b1;
         end
      end
   end

   // Frame decoder: one step per MDC rise. The read-data latch uses the
   // quiet clk after reg_rd so it never collides with a bit step.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         preCnt_q    <= '0;
         tmoCnt_q    <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         opFirst_q   <= 1'b0;
         isRead_q    <= 1'b0;
         mdo_q       <= 1'b1;
         mdt_q       <= 1'b1;
         busy_q      <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
      end else begin
         reg_wr_q <= 1'b0;
         reg_rd_q <= 1'b0;
         tmoCnt_q <= tmoCnt_d;
         if (tmoHit) begin
            state_q  <= S_IDLE;
            mdt_q    <= 1'b1;
            mdo_q    <= 1'b1;
            busy_q   <= 1'b0;
            bitCnt_q <= '0;
            preCnt_q <= '0;
         end else if (mdcRise) begin
            case (state_q)
               S_IDLE: begin
                  if ((mdiSync == ST[1]) && (preCnt_q == PRE_W'(PRE_MIN))) begin
                     state_q  <= S_ST2;
                     busy_q   <= 1'b1;
                     preCnt_q <= '0;
                  end else if (mdiSync) begin
                     if (preCnt_q != PRE_W'(PRE_MIN)) begin
                        preCnt_q <= preCnt_q + 1'b1;
                     end
                  end else begin
                     preCnt_q <= '0;
                  end
               end
               S_ST2: begin
                  bitCnt_q <= '0;
                  if (mdiSync == ST[0]) begin
                     state_q <= S_OP;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               S_OP: begin
                  if (bitCnt_q == 5'd0) begin
                     opFirst_q <= mdiSync;
                     bitCnt_q  <= 5'd1;
                  end else begin
                     bitCnt_q <= '0;
                     if ((opCode == OP_WR) || (opCode == OP_RD)) begin
                        isRead_q <= (opCode == OP_RD);
                        state_q  <= S_PHYAD;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               S_PHYAD: begin
                  shift_q <= {shift_q[DATA_W-2:0], mdiSync};
                  if (bitCnt_q == 5'(PHYAD_W - 1)) begin
                     bitCnt_q <= '0;
                     state_q  <= addrMatch ? S_REGAD : S_SKIP;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
               S_REGAD: begin
                  shift_q <= {shift_q[DATA_W-2:0], mdiSync};
                  if (bitCnt_q == 5'(REGAD_W - 1)) begin
                     bitCnt_q   <= '0;
                     reg_addr_q <= fieldVal;
                     reg_rd_q   <= isRead_q;
                     state_q    <= S_TA;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
               S_TA: begin
                  if (bitCnt_q != 5'(TA_W - 1)) begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                     if (isRead_q) begin
                        mdt_q <= 1'b0;
                        mdo_q <= 1'b0;
                     end
                  end else begin
                     bitCnt_q <= '0;
                     if (isRead_q) begin
                        mdo_q   <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        state_q <= S_RDATA;
                     end else begin
                        state_q <= S_WDATA;
                     end
                  end
               end
               S_WDATA: begin
                  shift_q <= {shift_q[DATA_W-2:0], mdiSync};
                  if (bitCnt_q == 5'(DATA_W - 1)) begin
                     bitCnt_q    <= '0;
                     reg_wdata_q <= {shift_q[DATA_W-2:0], mdiSync};
                     reg_wr_q    <= 1'b1;
                     state_q     <= S_IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
               S_RDATA: begin
                  if (bitCnt_q == 5'(DATA_W - 1)) begin
                     bitCnt_q <= '0;
                     mdt_q    <= 1'b1;
                     mdo_q    <= 1'b1;
                     state_q  <= S_IDLE;
                     busy_q   <= 1'b0;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                     mdo_q    <= shift_q[DATA_W-1];
                     shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
                  end
               end
               S_SKIP: begin
                  if (bitCnt_q == 5'(SKIP_BITS - 1)) begin
                     bitCnt_q <= '0;
                     state_q  <= S_IDLE;
                     busy_q   <= 1'b0;
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q  <= S_IDLE;
                  mdt_q    <= 1'b1;
                  mdo_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  bitCnt_q <= '0;
               end
            endcase
         end else if (reg_rd_q) begin
            shift_q <= reg_rdata_i;
         end
      end
   end

   assign mdo_o       = mdo_q;
   assign mdt_o       = mdt_q;
   assign busy_o      = busy_q;
   assign reg_wr_o    = reg_wr_q;
   assign reg_rd_o    = reg_rd_q;
   assign reg_addr_o  = reg_addr_q;
   assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_mdio_slave_if.sv
// Directed bench: a station model drives MDC/MDIO frames onto a shared bus
// with two responders (PHYA=1 unicast-only, PHYA=3 with broadcast writes).
module tb_mdio_slave_if;

   localparam int TMO = 4096;

   logic clk = 1'b0;
   logic rst_n;
   logic mdc;
   logic stationOe;
   logic stationOut;
   logic busLine;

   logic        mdoA, mdtA, wrA, rdA, busyA;
   logic [4:0]  addrA;
   logic [15:0] wdataA, rdataA;
   logic        mdoB, mdtB, wrB, rdB, busyB;
   logic [4:0]  addrB;
   logic [15:0] wdataB, rdataB;

   int          wrCntA, wrCntB, rdCntA, rdCntB, lowCntA, lowCntB;
   logic [4:0]  lastAddrA, lastAddrB;
   logic [15:0] lastDataA, lastDataB;

   int          wrA0, wrB0, rdA0, rdB0, lowA0, lowB0;
   logic [31:0] mdtLogA;
   logic [15:0] lastRead;
   int          errors = 0;
   int          checks = 0;

   // System clock, 10 ns period.
   always #5 clk = ~clk;

   // Open-drain style bus: station, then either responder, else pull-up.
   assign busLine = stationOe ? stationOut : (!mdtA ? mdoA : (!mdtB ? mdoB : 1'b1));

   mdio_slave_if #(.PHYA(5'd1), .PRE_MIN(32), .BCAST_EN(1'b0), .TIMEOUT(TMO)) dutA (
      .clk_i(clk), .rst_ni(rst_n), .mdc_i(mdc), .mdi_i(busLine),
      .mdo_o(mdoA), .mdt_o(mdtA), .reg_addr_o(addrA), .reg_wr_o(wrA),
      .reg_wdata_o(wdataA), .reg_rd_o(rdA), .reg_rdata_i(rdataA), .busy_o(busyA)
   );

   mdio_slave_if #(.PHYA(5'd3), .PRE_MIN(32), .BCAST_EN(1'b1), .TIMEOUT(TMO)) dutB (
      .clk_i(clk), .rst_ni(rst_n), .mdc_i(mdc), .mdi_i(busLine),
      .mdo_o(mdoB), .mdt_o(mdtB), .reg_addr_o(addrB), .reg_wr_o(wrB),
      .reg_wdata_o(wdataB), .reg_rd_o(rdB), .reg_rdata_i(rdataB), .busy_o(busyB)
   );

   // Register-port monitors: strobe counts, captured write data, drive time.
   always @(posedge clk) begin
      if (wrA) begin
         wrCntA    <= wrCntA + 1;
         lastAddrA <= addrA;
         lastDataA <= wdataA;
      end
      if (wrB) begin
         wrCntB    <= wrCntB + 1;
         lastAddrB <= addrB;
         lastDataB <= wdataB;
      end
      if (rdA) rdCntA <= rdCntA + 1;
      if (rdB) rdCntB <= rdCntB + 1;
      if (!mdtA) lowCntA <= lowCntA + 1;
      if (!mdtB) lowCntB <= lowCntB + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One MDC period (8 clk): drive during low phase, sample just before the rise.
   task automatic mdcCycle(input logic drv, input logic val, output logic smp, output logic mdtSmp);
      stationOe  = drv;
      stationOut = val;
      repeat (4) @(negedge clk);
      smp    = busLine;
      mdtSmp = mdtA;
      mdc    = 1'b1;
      repeat (4) @(negedge clk);
      mdc = 1'b0;
   endtask

   task automatic snap();
      wrA0  = wrCntA;  wrB0  = wrCntB;
      rdA0  = rdCntA;  rdB0  = rdCntB;
      lowA0 = lowCntA; lowB0 = lowCntB;
   endtask

   // Preamble plus the first nBits of a 32-bit frame; reads release the bus from TA.
   task automatic applyStimulus(input int preLen, input logic [1:0] st, input logic [1:0] op,
                                input logic [4:0] phy, input logic [4:0] rega,
                                input logic [15:0] data, input int nBits);
      logic [31:0] frame;
      logic        smp;
      logic        mdtSmp;
      logic        isRead;
      frame  = {st, op, phy, rega, 2'b10, data};
      isRead = (op == 2'b10);
      snap();
      mdtLogA = '1;
      for (int i = 0; i < preLen; i++) mdcCycle(1'b1, 1'b1, smp, mdtSmp);
      for (int i = 0; i < nBits; i++) begin
         mdcCycle(!(isRead && i >= 14), frame[31-i], smp, mdtSmp);
         mdtLogA[i] = mdtSmp;
         if (i >= 16) lastRead[31-i] = smp;
      end
      stationOe = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      mdc        = 1'b0;
      stationOe  = 1'b0;
      stationOut = 1'b1;
      rdataA     = 16'h0000;
      rdataB     = 16'hDEAD;
      lastRead   = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs_A", 32'({mdtA, mdoA, busyA, wrA, rdA, addrA, wdataA}),
                  32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0}));
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] write PHY1 REG1e A001");
      applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'h1e, 16'hA001, 32);
      checkOutput("wr1_count", 32'(wrCntA - wrA0), 32'd1);
      checkOutput("wr1_addr", 32'(lastAddrA), 32'h1e);
      checkOutput("wr1_data", 32'(lastDataA), 32'hA001);
      checkOutput("wr1_no_drive", 32'(lowCntA - lowA0), 32'd0);
      checkOutput("wr1_busy_end", 32'(busyA), 32'd0);
      checkOutput("wr1_B_quiet", 32'(wrCntB - wrB0), 32'd0);

      $display("[TB] read PHY1 REG3");
      rdataA = 16'h1234;
      applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0000, 32);
      checkOutput("rd2_data", 32'(lastRead), 32'h1234);
      checkOutput("rd2_strobe", 32'(rdCntA - rdA0), 32'd1);
      checkOutput("rd2_addr", 32'(addrA), 32'd3);
      checkOutput("rd2_ta1_released", 32'(mdtLogA[14]), 32'd1);
      checkOutput("rd2_driven_ta2_d0", 32'(mdtLogA[31:15]), 32'd0);
      checkOutput("rd2_release_end", 32'({mdtA, mdoA, busyA}), 32'b110);
      checkOutput("rd2_no_write", 32'(wrCntA - wrA0), 32'd0);

      $display("[TB] write to foreign PHY2");
      applyStimulus(32, 2'b01, 2'b01, 5'd2, 5'd4, 16'hFFFF, 32);
      checkOutput("wr3_A_ignored", 32'(wrCntA - wrA0), 32'd0);
      checkOutput("wr3_B_ignored", 32'(wrCntB - wrB0), 32'd0);
      checkOutput("wr3_no_drive", 32'((lowCntA - lowA0) + (lowCntB - lowB0)), 32'd0);
      applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd7, 16'h00FF, 32);
      checkOutput("wr3_next_count", 32'(wrCntA - wrA0), 32'd1);
      checkOutput("wr3_next_data", 32'({lastAddrA, lastDataA}), 32'({5'd7, 16'h00FF}));

      $display("[TB] short preamble and broadcast");
      applyStimulus(31, 2'b01, 2'b01, 5'd1, 5'd2, 16'h5555, 32);
      checkOutput("pre31_ignored", 32'(wrCntA - wrA0), 32'd0);
      checkOutput("pre31_busy", 32'(busyA), 32'd0);
      applyStimulus(32, 2'b01, 2'b01, 5'd0, 5'd9, 16'hC3C3, 32);
      checkOutput("bcast_wr_B", 32'(wrCntB - wrB0), 32'd1);
      checkOutput("bcast_wr_B_data", 32'({lastAddrB, lastDataB}), 32'({5'd9, 16'hC3C3}));
      checkOutput("bcast_wr_A_off", 32'(wrCntA - wrA0), 32'd0);
      applyStimulus(32, 2'b01, 2'b10, 5'd0, 5'd9, 16'h0000, 32);
      checkOutput("bcast_rd_no_strobe", 32'((rdCntA - rdA0) + (rdCntB - rdB0)), 32'd0);
      checkOutput("bcast_rd_no_drive", 32'((lowCntA - lowA0) + (lowCntB - lowB0)), 32'd0);
      checkOutput("bcast_rd_line_idle", 32'(lastRead), 32'hFFFF);

      $display("[TB] MDC stall timeout");
      applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd6, 16'hBEEF, 24);
      checkOutput("tmo_busy_open", 32'(busyA), 32'd1);
      repeat (TMO - 20) @(negedge clk);
      checkOutput("tmo_busy_before", 32'(busyA), 32'd1);
      repeat (30) @(negedge clk);
      checkOutput("tmo_busy_after", 32'(busyA), 32'd0);
      checkOutput("tmo_no_write", 32'(wrCntA - wrA0), 32'd0);
      checkOutput("tmo_mdt", 32'(mdtA), 32'd1);
      applyStimulus(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h0F0F, 32);
      checkOutput("tmo_recover", 32'({lastAddrA, lastDataA}), 32'({5'd4, 16'h0F0F}));
      checkOutput("tmo_recover_cnt", 32'(wrCntA - wrA0), 32'd1);

      $display("[TB] reset during read data");
      rdataA = 16'h5A5A;
      applyStimulus(32, 2'b01, 2'b10, 5'd1, 5'd8, 16'h0000, 21);
      checkOutput("rst_mid_driving", 32'(mdtA), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_release", 32'({mdtA, mdoA, busyA}), 32'b110);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] bad OP and bad ST");
      applyStimulus(32, 2'b01, 2'b11, 5'd1, 5'd0, 16'h0000, 32);
      checkOutput("op11_strobes", 32'((wrCntA - wrA0) + (rdCntA - rdA0)), 32'd0);
      checkOutput("op11_no_drive", 32'(lowCntA - lowA0), 32'd0);
      checkOutput("op11_idle", 32'(busyA), 32'd0);
      applyStimulus(32, 2'b00, 2'b01, 5'd1, 5'd0, 16'h0000, 32);
      checkOutput("st00_strobes", 32'((wrCntA - wrA0) + (rdCntA - rdA0)), 32'd0);
      checkOutput("st00_no_drive", 32'(lowCntA - lowA0), 32'd0);
      checkOutput("st00_idle", 32'({busyA, mdtA}), 32'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
